// File: rtl/exp3_uc_pkg.sv
// Shared definitions for the Experiment 3 control unit: state codes shown on
// the hex display and the default ESPERA timeout length.
package exp3_uc_pkg;

    localparam logic [3:0] EST_INICIAL     = 4'b0000;
    localparam logic [3:0] EST_PREPARA     = 4'b0001;
    localparam logic [3:0] EST_ESPERA      = 4'b0010;
    localparam logic [3:0] EST_REGISTRA    = 4'b0100;
    localparam logic [3:0] EST_COMPARA     = 4'b0101;
    localparam logic [3:0] EST_PROXIMO     = 4'b0110;
    localparam logic [3:0] EST_FIM_ACERTO  = 4'b1010;
    localparam logic [3:0] EST_FIM_ERRO    = 4'b1110;
    localparam logic [3:0] EST_FIM_TIMEOUT = 4'b1101;

    localparam int UC_TIMEOUT_CYCLES_DEF = 5000;

    typedef enum logic [3:0] {
        INICIAL     = EST_INICIAL,
        PREPARA     = EST_PREPARA,
        ESPERA      = EST_ESPERA,
        REGISTRA    = EST_REGISTRA,
        COMPARA     = EST_COMPARA,
        PROXIMO     = EST_PROXIMO,
        FIM_ACERTO  = EST_FIM_ACERTO,
        FIM_ERRO    = EST_FIM_ERRO,
        FIM_TIMEOUT = EST_FIM_TIMEOUT
    } estado_t;

endpackage

// File: rtl/exp3_uc_timer_espera.sv
// Wait counter for the ESPERA state: cleared by zera, counts while conta is
// high, and flags fim once it has reached TIMEOUT_CYCLES-1.
module exp3_uc_timer_espera
    import exp3_uc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = UC_TIMEOUT_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] ULTIMO = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] contagem;

    // Holds at the last value so fim stays asserted until the next clear.
    always_ff @(posedge clock) begin
        if (reset || zera) begin
            contagem <= '0;
        end else if (conta && (contagem != ULTIMO)) begin
            contagem <= contagem + W'(1);
        end
    end

    assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/exp3_unidade_controle.sv
// Moore control unit sequencing exp3_fluxo_dados through one game round.
// Optional ESPERA timeout enabled by defining UC_TIMEOUT_EN.
module exp3_unidade_controle
    import exp3_uc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = UC_TIMEOUT_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       fimC,
    input  logic       chavesIgualMemoria,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t estado;
    estado_t proximo;
    logic    fimEspera;

`ifdef UC_TIMEOUT_EN
    // Counter is held clear outside ESPERA, so every entry starts from zero.
    exp3_uc_timer_espera #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uTimerEspera (
        .clock(clock),
        .reset(reset),
        .zera (estado != ESPERA),
        .conta(estado == ESPERA),
        .fim  (fimEspera)
    );
`else
    // No wait counter: ESPERA never expires (expression is always false).
    assign fimEspera = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo   = INICIAL;
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado)
            INICIAL: begin
                proximo = iniciar ? PREPARA : INICIAL;
            end
            PREPARA: begin
                proximo = ESPERA;
                zeraC   = 1'b1;
                zeraR   = 1'b1;
            end
            ESPERA: begin
                // A play in the expiring cycle takes priority over the timeout.
                if (jogada) begin
                    proximo = REGISTRA;
                end else if (fimEspera) begin
                    proximo = FIM_TIMEOUT;
                end else begin
                    proximo = ESPERA;
                end
            end
            REGISTRA: begin
                proximo   = COMPARA;
                registraR = 1'b1;
            end
            COMPARA: begin
                if (!chavesIgualMemoria) begin
                    proximo = FIM_ERRO;
                end else if (fimC) begin
                    proximo = FIM_ACERTO;
                end else begin
                    proximo = PROXIMO;
                end
            end
            PROXIMO: begin
                proximo = ESPERA;
                contaC  = 1'b1;
            end
            FIM_ACERTO: begin
                proximo = iniciar ? PREPARA : FIM_ACERTO;
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                proximo = iniciar ? PREPARA : FIM_ERRO;
                pronto  = 1'b1;
                errou   = 1'b1;
            end
`ifdef UC_TIMEOUT_EN
            FIM_TIMEOUT: begin
                proximo = iniciar ? PREPARA : FIM_TIMEOUT;
                pronto  = 1'b1;
                timeout = 1'b1;
            end
`endif
            default: begin
                proximo = INICIAL;
            end
        endcase
    end

    assign db_estado = estado;

endmodule

// File: doc/exp3_unidade_controle.md
# exp3_unidade_controle

Moore control unit that sequences the Experiment 3 datapath (`exp3_fluxo_dados`) through one full game round. On `iniciar` it clears the address counter and the switch register. For each position it then waits for a play, registers the switches, checks them against memory, and advances the counter. It stops on the first mismatch or after position 15. It connects directly to the datapath's `zeraC`/`contaC`/`zeraR`/`registraR` inputs and `fimC`/`chavesIgualMemoria` outputs.

## Interface
- `TIMEOUT_CYCLES`, default 5000: number of cycles to wait in ESPERA before aborting. Only meaningful with `UC_TIMEOUT_EN`.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high. Forces INICIAL.
- `iniciar` in 1: start or restart request, level, sampled at the edge.
- `jogada` in 1: play strobe. Each sampled high in ESPERA counts as one play.
- `fimC` in 1: datapath counter is at 15.
- `chavesIgualMemoria` in 1: datapath comparator result.
- `zeraC` out 1: clear the counter.
- `contaC` out 1: increment the counter.
- `zeraR` out 1: clear the switch register.
- `registraR` out 1: load the switch register.
- `pronto` out 1: round finished (any final state).
- `acertou` out 1: all 16 positions matched.
- `errou` out 1: a mismatch occurred.
- `timeout` out 1: ESPERA expired. Tied to 0 without `UC_TIMEOUT_EN`.
- `db_estado` out 4: state code, driven to the hex display.

## Operation
- States and codes:
  - INICIAL 0000
  - PREPARA 0001
  - ESPERA 0010
  - REGISTRA 0100
  - COMPARA 0101
  - PROXIMO 0110
  - FIM_ACERTO 1010
  - FIM_ERRO 1110
  - FIM_TIMEOUT 1101
  - Any unused code returns to INICIAL on the next edge.
- Transitions:
  - INICIAL → PREPARA when `iniciar`=1; otherwise stays.
  - PREPARA → ESPERA unconditionally.
  - ESPERA → REGISTRA when `jogada`=1; otherwise stays. Timeout rule below.
  - REGISTRA → COMPARA unconditionally.
  - COMPARA → FIM_ERRO when `chavesIgualMemoria`=0.
  - COMPARA → FIM_ACERTO when `chavesIgualMemoria`=1 and `fimC`=1.
  - COMPARA → PROXIMO otherwise.
  - PROXIMO → ESPERA unconditionally.
  - FIM_* → PREPARA when `iniciar`=1; otherwise holds.
- Moore outputs, decoded from the state register only:
  - PREPARA: `zeraC`=`zeraR`=1.
  - REGISTRA: `registraR`=1.
  - PROXIMO: `contaC`=1.
  - FIM_ACERTO: `pronto`=`acertou`=1.
  - FIM_ERRO: `pronto`=`errou`=1.
  - FIM_TIMEOUT: `pronto`=`timeout`=1.
  - All other outputs are 0.
- At most one of `zeraC`/`contaC`/`registraR` is high in any cycle.
- `iniciar` is ignored outside INICIAL and FIM_*.
- `jogada` is ignored outside ESPERA.
- A `jogada` held high across PROXIMO is taken as a new play on re-entry to ESPERA. Edge detection is upstream's job.

## Timing
- Reset: state INICIAL and every output 0 (`db_estado`=0000) after the first edge with `reset`=1. Reset overrides all inputs, including mid-round.
- `iniciar` high at edge N: PREPARA in cycle N+1, ESPERA in N+2.
- Per position: `jogada` at edge N gives REGISTRA in N+1, COMPARA in N+2, then PROXIMO in N+3 and ESPERA in N+4.
- COMPARA sees the registered switches (loaded at the end of REGISTRA) against the memory at the current address. No extra wait cycle is needed.
- Best-case full round: iniciar→PREPARA, 1 cycle ESPERA per play, 16 compares, 15 increments. FIM_ACERTO is reached 2 + 16×3 + 15 = 65 cycles after `iniciar` is sampled.
- On the last position, `fimC`=1 in COMPARA. No PROXIMO follows, so the counter stays at 15.

## Configuration
- `UC_TIMEOUT_EN` defined:
  - A wait counter clears on every entry to ESPERA and increments each cycle spent in ESPERA.
  - When it reaches `TIMEOUT_CYCLES`-1 with `jogada`=0, the next state is FIM_TIMEOUT.
  - If `jogada`=1 in the expiring cycle, the play wins.
  - Counter width is `$clog2(TIMEOUT_CYCLES)`; it resets to 0.
- Not defined: no wait counter, ESPERA waits forever, `timeout`=0, and FIM_TIMEOUT is unreachable (decoded as unused).

## Structure
- Shared header/package `exp3_uc_pkg`: the nine 4-bit state-code constants and the default `TIMEOUT_CYCLES`. The display decoder and benches reuse them.
- One sub-module, instantiated only under `UC_TIMEOUT_EN`: `exp3_uc_timer_espera`.
  - Inputs: `clock`, `reset`, `zera`, `conta`.
  - Output: `fim`.
  - Parameterised by `TIMEOUT_CYCLES`.
- Next-state logic and output decode stay in the top module.

## Test plan
- Reset mid-round: reset while in COMPARA → next cycle `db_estado`=0000, all outputs 0; `iniciar`=0 keeps INICIAL.
- Start pulse: `iniciar` for 1 cycle → `zeraC`=`zeraR`=1 for exactly 1 cycle, then `db_estado`=0010 with all strobes 0.
- Mismatch: with the real datapath, switches 0001 (addr 0), then 0010 (addr 1), then 1000 (addr 2, memory 0100) → `errou`=`pronto`=1, `db_estado`=1110, counter=2.
- Full match: 16 correct plays → `acertou`=`pronto`=1 after 16 `registraR` and 15 `contaC` pulses, counter=15, `db_estado`=1010; `iniciar` restarts into PREPARA.
- Held `jogada`: held high for 10 cycles with matching data → a second REGISTRA occurs 4 cycles after the first.
- `UC_TIMEOUT_EN` with `TIMEOUT_CYCLES`=8:
  - No `jogada` → FIM_TIMEOUT (`db_estado`=1101, `timeout`=1) on the 9th cycle after entering ESPERA.
  - `jogada` on the 8th cycle → REGISTRA.
  - Without the macro, the same stimulus stays in ESPERA.
